param_edit_ctrl: RTL and testbench
==================================

Name: param_edit_ctrl

Overview:
- Button-driven editor for a bank of NUM_FIELDS parameter registers, e.g. rotation X/Y/Z and scale of the displayed 3D object.
- Schedules a single shared step/compare/wrap datapath across all fields. Only the selected field is modified in any cycle.
- Adds press-and-hold auto-repeat and field selection on top of the up/down step behaviour.
- Sits between the debounced front-panel buttons and the transform/render stage, which consumes the values bus and the update pulse.

Parameters:
- NUM_FIELDS, 4, number of parameter registers (2..8).
- SELW, 2, width of the field index; must satisfy 2^SELW >= NUM_FIELDS.
- WIDTH, 10, width of each field value.
- MIN, 0, lowest legal value (>= 0).
- MAX, 359, highest legal value (MAX < 2^WIDTH, MAX >= MIN).
- STEP, 1, amount added or subtracted per step (1..MAX-MIN).
- WRAP, 1, 1 = wrap at the range limits, 0 = saturate.
- REPEAT_DELAY, 8, cycles of hold after the first step before auto-repeat starts (>= 2).
- REPEAT_PERIOD, 4, cycles between auto-repeat steps (>= 1).

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  reset, synchronous, active-high.
- btn_up  in  1  increment the selected field; level, held = repeat.
- btn_down  in  1  decrement the selected field; level, held = repeat.
- btn_next  in  1  select the next field; acts on its rising edge.
- sel  out  SELW  index of the currently selected field.
- cur_value  out  WIDTH  value of the selected field (combinational mux of the field registers).
- values  out  NUM_FIELDS*WIDTH  all fields; field i occupies bits [i*WIDTH +: WIDTH].
- changing  out  1  one-cycle pulse when a field value has been updated.
- upd_field  out  SELW  index of the field updated; valid while changing=1.

Behaviour:
- Clock and reset: one clock (Clock); reset (resetn) is synchronous and active-high.
- Reset: all fields = MIN, sel = 0, changing = 0, upd_field = 0, FSM = IDLE, repeat counter = 0, input sample registers = 0. Reset mid-hold discards the hold; no step is issued until a new press.
- Input stage: btn_up, btn_down and btn_next are each registered once. Edges are detected against the previous registered sample. A field value updates on the 2nd rising edge after the button rises. changing and upd_field are registered and valid in the same cycle the new value appears.
- Step arithmetic: computed in WIDTH+1 bits.
  - up: if v+STEP > MAX, result = MIN if WRAP else MAX.
  - down: if v < MIN+STEP, result = MAX if WRAP else MIN (no unsigned underflow).
  - Saturated no-op (value unchanged): changing = 0. A wrap counts as a change: changing = 1.
- FSM, driven by registered up (u) and down (d):
  - IDLE: exactly one of u/d rising -> one step now, cnt = 0, go HOLD. Both rising together -> go WAIT_REL, no step.
  - HOLD: the pressed button drops -> IDLE. Other button also high -> WAIT_REL. Otherwise cnt++; when cnt == REPEAT_DELAY-1, step, cnt = 0, go REPEAT.
  - REPEAT: same release/conflict rules as HOLD; when cnt == REPEAT_PERIOD-1, step, cnt = 0.
  - WAIT_REL: stay until u=0 and d=0, then go IDLE.
- Resulting step schedule for a held button: steps at relative cycles 0, REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, and so on.
- Direction is fixed for the whole hold: the pressing button sets it.
- Field select:
  - A btn_next rising edge in IDLE sets sel = sel+1, wrapping to 0 after NUM_FIELDS-1 (independent of WRAP).
  - A btn_next edge in any other state is ignored, not queued. sel never changes while a hold is in progress.
  - A btn_next edge and an up/down edge in the same cycle in IDLE: the step is applied to the old sel, and sel advances in the same cycle.
- Non-selected fields: never modified except by reset.
- Unused sel codes (NUM_FIELDS < 2^SELW) are unreachable; cur_value returns field 0 for them.

Test Plan:
- Defaults, reset, then btn_up high 1 cycle -> field0: 0 -> 1 two edges later; changing=1 for exactly 1 cycle with upd_field=0; fields 1..3 stay 0.
- Field0=0, btn_down pulse: WRAP=1 -> field0=359, changing=1. WRAP=0 -> field0 stays 0, changing=0.
- REPEAT_DELAY=4, REPEAT_PERIOD=2, btn_up held 12 cycles from field0=358 (WRAP=1) -> steps at relative cycles 0,4,6,8,10; values 359,0,1,2,3; no steps after release.
- btn_next pulsed 5 times with NUM_FIELDS=4 -> sel sequence 1,2,3,0,1. Then btn_up pulse -> only field1 increments; cur_value tracks field1.
- Hold btn_up, assert btn_down at relative cycle 2 -> FSM goes to WAIT_REL, no further steps. Release both, then press btn_down -> a single decrement occurs.
- Hold btn_up into REPEAT, assert resetn for 1 cycle -> all fields = 0, sel = 0, changing = 0. No step while btn_up is still held; the next step requires release and re-press.

Source files
------------

// File: rtl/param_edit_ctrl.sv
// Button-driven editor for a bank of parameter registers with auto-repeat and field select.
// A single shared step/compare/wrap datapath updates only the selected field.
module param_edit_ctrl #(
  parameter int NUM_FIELDS    = 4,
  parameter int SELW          = 2,
  parameter int WIDTH         = 10,
  parameter int MIN           = 0,
  parameter int MAX           = 359,
  parameter int STEP          = 1,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                        Clock,
  input  logic                        resetn,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_next,
  output logic [SELW-1:0]             sel,
  output logic [WIDTH-1:0]            cur_value,
  output logic [NUM_FIELDS*WIDTH-1:0] values,
  output logic                        changing,
  output logic [SELW-1:0]             upd_field
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNTW    = $clog2(CNT_MAX) + 1;
  localparam logic [CNTW-1:0]  DLY_LAST = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0]  PER_LAST = CNTW'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   LOW_X    = (WIDTH+1)'(MIN + STEP);
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [SELW-1:0]  SEL_LAST = SELW'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;

  state_t           state, state_nx;
  logic [CNTW-1:0]  cnt, cnt_nx;
  logic             dir_q, dir_nx;
  logic             u_q, d_q, n_q, u_p, d_p, n_p;
  logic             rearm_wait;
  logic             rise_u, rise_d, rise_n;
  logic             pressed, other;
  logic             step_en, step_up, sel_adv;
  logic [WIDTH-1:0] fields [NUM_FIELDS];
  logic [WIDTH:0]   ext_v, up_sum, dn_diff;
  logic [WIDTH-1:0] new_v;

  // Buttons held through reset leave rearm_wait set, masking the spurious
  // rise seen once the cleared sample registers refill; a release re-arms.
  assign rise_u = u_q & ~u_p & ~rearm_wait;
  assign rise_d = d_q & ~d_p & ~rearm_wait;
  assign rise_n = n_q & ~n_p;

  always_comb begin
    cur_value = fields[0];
    for (int unsigned i = 0; i < NUM_FIELDS; i++)
      if (sel == SELW'(i)) cur_value = fields[i];
  end

  always_comb begin
    values = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++)
      values[i*WIDTH +: WIDTH] = fields[i];
  end

  always_comb begin
    ext_v   = {1'b0, cur_value};
    up_sum  = ext_v + STEP_X;
    dn_diff = ext_v - STEP_X;
    if (step_up) begin
      if (up_sum > MAX_X) new_v = (WRAP != 0) ? MIN_V : MAX_V;
      else                new_v = up_sum[WIDTH-1:0];
    end else begin
      if (ext_v < LOW_X)  new_v = (WRAP != 0) ? MAX_V : MIN_V;
      else                new_v = dn_diff[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    step_en  = 1'b0;
    step_up  = dir_q;
    sel_adv  = 1'b0;
    pressed  = dir_q ? u_q : d_q;
    other    = dir_q ? d_q : u_q;
    case (state)
      IDLE: begin
        sel_adv = rise_n;
        if (rise_u && rise_d) begin
          state_nx = WAIT_REL;
        end else if (rise_u || rise_d) begin
          step_en  = 1'b1;
          step_up  = rise_u;
          dir_nx   = rise_u;
          cnt_nx   = '0;
          state_nx = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (!pressed) begin
          state_nx = IDLE;
        end else if (other) begin
          state_nx = WAIT_REL;
        end else if (cnt == ((state == HOLD) ? DLY_LAST : PER_LAST)) begin
          step_en  = 1'b1;
          cnt_nx   = '0;
          state_nx = REPEAT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!u_q && !d_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (resetn) begin
      u_q        <= 1'b0;
      d_q        <= 1'b0;
      n_q        <= 1'b0;
      u_p        <= 1'b0;
      d_p        <= 1'b0;
      n_p        <= 1'b0;
      rearm_wait <= btn_up | btn_down;
      state      <= IDLE;
      cnt        <= '0;
      dir_q      <= 1'b0;
      sel        <= '0;
      changing   <= 1'b0;
      upd_field  <= '0;
      for (int unsigned i = 0; i < NUM_FIELDS; i++) fields[i] <= MIN_V;
    end else begin
      u_q   <= btn_up;
      d_q   <= btn_down;
      n_q   <= btn_next;
      u_p   <= u_q;
      d_p   <= d_q;
      n_p   <= n_q;
      state <= state_nx;
      cnt   <= cnt_nx;
      dir_q <= dir_nx;
      if (!btn_up && !btn_down && !u_q && !d_q) rearm_wait <= 1'b0;
      changing <= 1'b0;
      if (step_en) begin
        changing  <= (new_v != cur_value);
        upd_field <= sel;
      end
      for (int unsigned i = 0; i < NUM_FIELDS; i++)
        if (step_en && sel == SELW'(i)) fields[i] <= new_v;
      if (sel_adv) sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: tb/tb_param_edit_ctrl.sv
// Bench for param_edit_ctrl: a wrapping and a saturating instance share stimulus and
// are checked every cycle against an age-based behavioural model, plus literal checkpoints.
module tb_param_edit_ctrl;
  localparam int NF = 4;
  localparam int SW = 2;
  localparam int W  = 10;
  localparam int MN = 0;
  localparam int MX = 359;
  localparam int ST = 1;
  localparam int RD = 4;
  localparam int RP = 2;

  logic Clock = 1'b0;
  logic resetn = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_next = 1'b0;

  logic [SW-1:0]   sel_w, upd_w, sel_s, upd_s;
  logic [W-1:0]    cur_w, cur_s;
  logic [NF*W-1:0] vals_w, vals_s;
  logic            chg_w, chg_s;

  param_edit_ctrl #(.NUM_FIELDS(NF), .SELW(SW), .WIDTH(W), .MIN(MN), .MAX(MX), .STEP(ST),
    .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_wrap (
    .Clock(Clock), .resetn(resetn), .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next),
    .sel(sel_w), .cur_value(cur_w), .values(vals_w), .changing(chg_w), .upd_field(upd_w));

  param_edit_ctrl #(.NUM_FIELDS(NF), .SELW(SW), .WIDTH(W), .MIN(MN), .MAX(MX), .STEP(ST),
    .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_sat (
    .Clock(Clock), .resetn(resetn), .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next),
    .sel(sel_s), .cur_value(cur_s), .values(vals_s), .changing(chg_s), .upd_field(upd_s));

  always #5 Clock = ~Clock;

  int tests = 0, errors = 0;
  bit started = 1'b0;
  int cc_w = 0, cc_s = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input logic [NF*W-1:0] v, input int i);
    return int'(v[i*W +: W]);
  endfunction

  // Reference: the hold is described by its age in cycles since the press;
  // steps fall at age 0, RD, RD+RP, RD+2*RP, ...
  int  m_fields [2][NF];
  bit  m_chg [2];
  int  m_sel, m_upd, mode, age;
  bit  mdir, blocked;
  bit  mu1, mu2, md1, md2, mn1, mn2;

  function automatic int step_val(input int v, input bit up, input bit wrap);
    if (up) return (v + ST > MX) ? (wrap ? MN : MX) : v + ST;
    return (v < MN + ST) ? (wrap ? MX : MN) : v - ST;
  endfunction

  always @(posedge Clock) begin
    bit ru, rd, rn, do_step, prs, oth;
    int s_old, nv;
    if (resetn) begin
      for (int k = 0; k < 2; k++) begin
        m_chg[k] = 1'b0;
        for (int i = 0; i < NF; i++) m_fields[k][i] = MN;
      end
      m_sel = 0; m_upd = 0; mode = 0; age = 0; mdir = 1'b0;
      blocked = btn_up | btn_down;
      {mu1, mu2, md1, md2, mn1, mn2} = '0;
    end else begin
      ru = mu1 && !mu2 && !blocked;
      rd = md1 && !md2 && !blocked;
      rn = mn1 && !mn2;
      do_step = 1'b0;
      s_old = m_sel;
      case (mode)
        0: begin
          if (ru && rd) mode = 2;
          else if (ru || rd) begin mdir = ru; age = 0; do_step = 1'b1; mode = 1; end
          if (rn) m_sel = (m_sel + 1) % NF;
        end
        1: begin
          prs = mdir ? mu1 : md1;
          oth = mdir ? md1 : mu1;
          if (!prs) mode = 0;
          else if (oth) mode = 2;
          else begin
            age++;
            if (age >= RD && (age - RD) % RP == 0) do_step = 1'b1;
          end
        end
        default: if (!mu1 && !md1) mode = 0;
      endcase
      for (int k = 0; k < 2; k++) begin
        m_chg[k] = 1'b0;
        if (do_step) begin
          nv = step_val(m_fields[k][s_old], mdir, k == 0);
          m_chg[k] = (nv != m_fields[k][s_old]);
          m_fields[k][s_old] = nv;
        end
      end
      if (do_step) m_upd = s_old;
      if (!btn_up && !btn_down && !mu1 && !md1) blocked = 1'b0;
      mu2 = mu1; md2 = md1; mn2 = mn1;
      mu1 = btn_up; md1 = btn_down; mn1 = btn_next;
    end
  end

  always @(negedge Clock) begin
    if (started) begin
      check("sel_w", int'(sel_w), m_sel);
      check("sel_s", int'(sel_s), m_sel);
      check("cur_w", int'(cur_w), m_fields[0][m_sel]);
      check("cur_s", int'(cur_s), m_fields[1][m_sel]);
      for (int i = 0; i < NF; i++) begin
        check("field_w", fld(vals_w, i), m_fields[0][i]);
        check("field_s", fld(vals_s, i), m_fields[1][i]);
      end
      check("chg_w", int'(chg_w), int'(m_chg[0]));
      check("chg_s", int'(chg_s), int'(m_chg[1]));
      if (m_chg[0]) check("upd_w", int'(upd_w), m_upd);
      if (m_chg[1]) check("upd_s", int'(upd_s), m_upd);
      if (chg_w) cc_w++;
      if (chg_s) cc_s++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic pulse_up();   btn_up = 1'b1;   cyc(1); btn_up = 1'b0;   cyc(4); endtask
  task automatic pulse_down(); btn_down = 1'b1; cyc(1); btn_down = 1'b0; cyc(4); endtask

  initial begin
    int exp_sel [5] = '{1, 2, 3, 0, 1};
    int saved_w, saved_s;
    cyc(1);
    started = 1'b1;
    cyc(2);
    resetn = 1'b0;
    check("rst_sel", int'(sel_w), 0);
    check("rst_f0", fld(vals_w, 0), 0);
    check("rst_chg", int'(chg_w), 0);

    pulse_up();
    check("up_f0_w", fld(vals_w, 0), 1);
    check("up_f0_s", fld(vals_s, 0), 1);
    check("up_f1_w", fld(vals_w, 1), 0);
    check("up_pulses", cc_w, 1);

    pulse_down();
    pulse_down();
    check("wrap_dn_f0", fld(vals_w, 0), 359);
    check("sat_dn_f0", fld(vals_s, 0), 0);
    check("sat_dn_cnt", cc_s, 2);

    pulse_down();
    check("dn_358", fld(vals_w, 0), 358);
    btn_up = 1'b1; cyc(12); btn_up = 1'b0; cyc(6);
    check("rep_f0_w", fld(vals_w, 0), 3);
    check("rep_f0_s", fld(vals_s, 0), 5);
    check("rep_cnt_w", cc_w, 9);
    check("rep_cnt_s", cc_s, 7);

    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1; cyc(1); btn_next = 1'b0; cyc(3);
      check("next_sel", int'(sel_w), exp_sel[i]);
    end
    pulse_up();
    check("f1_up", fld(vals_w, 1), 1);
    check("f0_keep", fld(vals_w, 0), 3);
    check("cur_f1", int'(cur_w), 1);

    btn_up = 1'b1; cyc(2); btn_down = 1'b1; cyc(10);
    btn_up = 1'b0; btn_down = 1'b0; cyc(4);
    check("conflict_f1", fld(vals_w, 1), 2);
    pulse_down();
    check("after_conf_f1", fld(vals_w, 1), 1);

    btn_up = 1'b1; cyc(10);
    check("hold_f1", fld(vals_w, 1), 5);
    resetn = 1'b1; cyc(1); resetn = 1'b0;
    check("mid_rst_f1", fld(vals_w, 1), 0);
    check("mid_rst_sel", int'(sel_w), 0);
    check("mid_rst_chg", int'(chg_w), 0);
    saved_w = cc_w; saved_s = cc_s;
    cyc(8);
    check("held_no_step", cc_w - saved_w, 0);
    check("held_f0", fld(vals_w, 0), 0);
    btn_up = 1'b0; cyc(3);
    pulse_up();
    check("repress_f0", fld(vals_w, 0), 1);
    check("repress_cnt", cc_s - saved_s, 1);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(5) == 0) btn_up = ~btn_up;
      if ($urandom_range(8) == 0) btn_down = ~btn_down;
      if ($urandom_range(6) == 0) btn_next = ~btn_next;
      resetn = ($urandom_range(399) == 0);
      cyc(1);
    end
    resetn = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0;
    cyc(6);
    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
